dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: port 0 = core load/store path, port 1 = debug/DMA loader.
- Each requester uses a valid/ready request and a one-cycle response pulse.
- Arbiter latches one transaction, drives the memory write/read signals for exactly one cycle, captures and size-masks read data, then returns the response.
- Sits between the core and the byte-addressed data memory; the memory read is combinational and the write is clocked.

---
 rtl/dmem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single byte-addressed data memory.
// Each accepted request runs a fixed IDLE -> ACCESS -> RESP sequence (response two cycles after accept).
module dmem_port_arbiter #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [1:0]        req_size0,
    input  logic [1:0]        req_size1,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [31:0]       req_wdata0,
    input  logic [31:0]       req_wdata1,
    output logic [1:0]        rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic              mem_write_en,
    output logic [31:0]       mem_write_data,
    output logic [1:0]        mem_write_command,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t              state_q, state_d;
    logic                last_grant_q;
    logic                owner_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic [31:0]         rdata_q;

    logic [1:0]          grant_s;
    logic                win_port_s;
    logic                acc_we_s;
    logic [1:0]          acc_size_s;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [31:0]         acc_wdata_s;
    logic [ADDR_W:0]     nbytes_s;
    logic [ADDR_W:0]     end_addr_s;
    logic                acc_err_s;

    function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] res;
        case (size)
            2'b00:   res = {24'h000000, data[7:0]};
            2'b01:   res = {16'h0000, data[15:0]};
            2'b10:   res = data;
            default: res = 32'h00000000;
        endcase
        return res;
    endfunction

    // Round-robin winner selection; only offered in IDLE and never while reset is asserted.
    always_comb begin
        grant_s = 2'b00;
        if ((state_q == S_IDLE) && resetn) begin
            case (req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_grant_q ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    assign req_ready   = grant_s;
    assign win_port_s  = grant_s[1];
    assign acc_we_s    = win_port_s ? req_we[1]  : req_we[0];
    assign acc_size_s  = win_port_s ? req_size1  : req_size0;
    assign acc_addr_s  = win_port_s ? req_addr1  : req_addr0;
    assign acc_wdata_s = win_port_s ? req_wdata1 : req_wdata0;

    // Range check runs one bit wider than the address so a wrapping access counts as out of range.
    always_comb begin
        nbytes_s = (ADDR_W+1)'(4);
        case (acc_size_s)
            2'b00:   nbytes_s = (ADDR_W+1)'(1);
            2'b01:   nbytes_s = (ADDR_W+1)'(2);
            2'b10:   nbytes_s = (ADDR_W+1)'(4);
            default: nbytes_s = (ADDR_W+1)'(4);
        endcase
    end

    assign end_addr_s = {1'b0, acc_addr_s} + nbytes_s;
    assign acc_err_s  = (acc_size_s == 2'b11) || (end_addr_s > MEM_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = (grant_s != 2'b00) ? S_ACCESS : S_IDLE;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Transaction capture at accept and read-data capture during the access cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= 32'h00000000;
            err_q        <= 1'b0;
            rdata_q      <= 32'h00000000;
        end else if (grant_s != 2'b00) begin
            last_grant_q <= win_port_s;
            owner_q      <= win_port_s;
            we_q         <= acc_we_s;
            size_q       <= acc_size_s;
            addr_q       <= acc_addr_s;
            wdata_q      <= acc_wdata_s;
            err_q        <= acc_err_s;
        end else if (state_q == S_ACCESS) begin
            rdata_q <= (we_q || err_q) ? 32'h00000000 : size_mask(size_q, mem_read_data);
        end
    end

    // Outputs decoded from state; everything is zero outside its owning state.
    always_comb begin
        mem_write_address = '0;
        mem_read_address  = '0;
        mem_write_en      = 1'b0;
        mem_write_data    = 32'h00000000;
        mem_write_command = 2'b00;
        rsp_valid         = 2'b00;
        rsp_err           = 1'b0;
        rsp_rdata         = 32'h00000000;
        case (state_q)
            S_ACCESS: begin
                mem_write_address = addr_q;
                mem_read_address  = addr_q;
                mem_write_en      = we_q & ~err_q;
                mem_write_data    = wdata_q;
                mem_write_command = size_q;
            end
            S_RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                rsp_err   = err_q;
                rsp_rdata = rdata_q;
            end
            default: begin
                rsp_valid = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed, table-driven bench for dmem_port_arbiter with a behavioural byte memory.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid, req_ready, req_we;
    logic [1:0]  req_size0, req_size1;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_write_address, mem_write_data, mem_read_address, mem_read_data;
    logic        mem_write_en;
    logic [1:0]  mem_write_command;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [7:0] mem [128];

    dmem_port_arbiter #(.MEM_BYTES(128), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size0(req_size0), .req_size1(req_size1),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_write_address(mem_write_address), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_write_command(mem_write_command),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic bit in_range(input logic [31:0] a, input int i);
        return ({1'b0, a} + 33'(i)) < 33'd128;
    endfunction

    function automatic int cmd_bytes(input logic [1:0] c);
        case (c)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    // Behavioural memory: clocked write, combinational little-endian read.
    always_ff @(posedge clk) begin
        if (mem_write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i < cmd_bytes(mem_write_command) && in_range(mem_write_address, i))
                    mem[mem_write_address[6:0] + 7'(i)] <= mem_write_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        mem_read_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (in_range(mem_read_address, i))
                mem_read_data[8*i +: 8] = mem[mem_read_address[6:0] + 7'(i)];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    task automatic drive_port(input int p, input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        if (p == 0) begin
            req_size0 = size; req_addr0 = addr; req_wdata0 = wdata;
        end else begin
            req_size1 = size; req_addr1 = addr; req_wdata1 = wdata;
        end
    endtask

    // Waits at falling edges for a nonzero ready; returns 0 on timeout.
    task automatic wait_ready(output bit ok);
        int waited = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        ok = (req_ready != 2'b00);
        if (!ok) chk("ready_timeout", {30'h0, req_ready}, 32'h1);
    endtask

    task automatic run_txn(input vec_t v);
        bit ok;
        logic [1:0] own;
        own = (v.port == 1) ? 2'b10 : 2'b01;
        req_valid = 2'b00;
        drive_port(v.port, v.we, v.size, v.addr, v.wdata);
        wait_ready(ok);
        if (!ok) begin
            req_valid = 2'b00;
            return;
        end
        chk("ready_onehot", {30'h0, req_ready}, {30'h0, own});
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("acc_wen", {31'h0, mem_write_en}, {31'h0, v.we & ~v.err});
        chk("acc_waddr", mem_write_address, v.addr);
        chk("acc_raddr", mem_read_address, v.addr);
        chk("acc_cmd", {30'h0, mem_write_command}, {30'h0, v.size});
        chk("acc_rspv", {30'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        chk("rsp_valid", {30'h0, rsp_valid}, {30'h0, own});
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, v.err});
        chk("rsp_rdata", rsp_rdata, v.rdata);
        chk("rsp_wen", {31'h0, mem_write_en}, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, {30'h0, req_ready}, 32'h0);
        chk({tag, "_rspv"}, {30'h0, rsp_valid}, 32'h0);
        chk({tag, "_rsperr"}, {31'h0, rsp_err}, 32'h0);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_wen"}, {31'h0, mem_write_en}, 32'h0);
        chk({tag, "_waddr"}, mem_write_address, 32'h0);
        chk({tag, "_wdata"}, mem_write_data, 32'h0);
        chk({tag, "_raddr"}, mem_read_address, 32'h0);
    endtask

    vec_t vecs[20];

    initial begin
        bit ok;
        logic [1:0] exp_g;

        vecs[0]  = '{0, 1'b1, 2'b10, 32'd8,   32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{0, 1'b0, 2'b10, 32'd8,   32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1, 1'b1, 2'b10, 32'd0,   32'hF00F81AA, 1'b0, 32'h0};
        vecs[3]  = '{1, 1'b0, 2'b00, 32'd0,   32'h0,        1'b0, 32'h000000AA};
        vecs[4]  = '{1, 1'b0, 2'b01, 32'd0,   32'h0,        1'b0, 32'h000081AA};
        vecs[5]  = '{1, 1'b0, 2'b10, 32'd0,   32'h0,        1'b0, 32'hF00F81AA};
        vecs[6]  = '{0, 1'b1, 2'b10, 32'd124, 32'h55667788, 1'b0, 32'h0};
        vecs[7]  = '{0, 1'b1, 2'b10, 32'd126, 32'h12345678, 1'b1, 32'h0};
        vecs[8]  = '{0, 1'b0, 2'b00, 32'd126, 32'h0,        1'b0, 32'h00000066};
        vecs[9]  = '{1, 1'b0, 2'b11, 32'd0,   32'h0,        1'b1, 32'h0};
        vecs[10] = '{1, 1'b0, 2'b00, 32'hFFFFFFFF, 32'h0,   1'b1, 32'h0};
        vecs[11] = '{0, 1'b1, 2'b10, 32'd16,  32'h11223344, 1'b0, 32'h0};
        vecs[12] = '{1, 1'b1, 2'b00, 32'd17,  32'hFFFFFFAB, 1'b0, 32'h0};
        vecs[13] = '{0, 1'b1, 2'b01, 32'd18,  32'h0000CDEF, 1'b0, 32'h0};
        vecs[14] = '{1, 1'b0, 2'b10, 32'd16,  32'h0,        1'b0, 32'hCDEFAB44};
        vecs[15] = '{0, 1'b0, 2'b01, 32'd127, 32'h0,        1'b1, 32'h0};
        vecs[16] = '{0, 1'b0, 2'b00, 32'd127, 32'h0,        1'b0, 32'h00000055};
        vecs[17] = '{1, 1'b1, 2'b10, 32'd20,  32'h0BADF00D, 1'b0, 32'h0};
        vecs[18] = '{0, 1'b0, 2'b10, 32'd20,  32'h0,        1'b0, 32'h0BADF00D};
        vecs[19] = '{1, 1'b1, 2'b11, 32'd24,  32'hCAFECAFE, 1'b1, 32'h0};

        // Reset with both requests pending: every output must stay zero.
        resetn = 1'b0;
        req_valid = 2'b11; req_we = 2'b00;
        req_size0 = 2'b10; req_size1 = 2'b10;
        req_addr0 = 32'd0; req_addr1 = 32'd0;
        req_wdata0 = 32'h0; req_wdata1 = 32'h0;
        #12;
        check_all_zero("reset");
        req_valid = 2'b00;
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) run_txn(vecs[i]);

        // Contention right after reset: grants alternate starting with port 0.
        resetn = 1'b0; #2; resetn = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        drive_port(0, 1'b0, 2'b10, 32'd8, 32'h0);
        drive_port(1, 1'b0, 2'b00, 32'd0, 32'h0);
        for (int g = 0; g < 4; g++) begin
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            wait_ready(ok);
            if (!ok) break;
            chk("tie_grant", {30'h0, req_ready}, {30'h0, exp_g});
            @(posedge clk);
            @(negedge clk);
            chk("tie_acc_ready", {30'h0, req_ready}, 32'h0);
            @(negedge clk);
            chk("tie_rspv", {30'h0, rsp_valid}, {30'h0, exp_g});
            chk("tie_rdata", rsp_rdata, (g % 2 == 0) ? 32'hDEADBEEF : 32'h000000AA);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;

        // Reset during the access cycle of a store to addr 20.
        drive_port(0, 1'b1, 2'b10, 32'd20, 32'h99999999);
        wait_ready(ok);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rst_pre_wen", {31'h0, mem_write_en}, 32'h1);
        #1;
        resetn = 1'b0;
        drive_port(0, 1'b0, 2'b10, 32'd20, 32'h0);
        drive_port(1, 1'b0, 2'b00, 32'd0, 32'h0);
        #1;
        check_all_zero("rst_mid");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_hold_rspv", {30'h0, rsp_valid}, 32'h0);
            chk("rst_hold_wen", {31'h0, mem_write_en}, 32'h0);
        end
        resetn = 1'b1;
        #1;
        chk("rst_tie_grant", {30'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_load_rspv", {30'h0, rsp_valid}, 32'h1);
        chk("rst_load_rdata", rsp_rdata, 32'h0BADF00D);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
